// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline register: operand-select encoding,
// datapath widths and the packed record latched between decode and execute.
package pipe_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SRC_RR    = 2'd0,
    SRC_RI    = 2'd1,
    SRC_SHAMT = 2'd2,
    SRC_SHV   = 2'd3
  } src_sel_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_op;
    src_sel_t          src_sel;
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  shamt;
    logic              wr_en;
    logic [REG_W-1:0]  wr_addr;
    logic              mem_read;
  } id_ex_t;

  // A result bus forwards only to a real, matching register (r0 is hardwired).
  function automatic logic bus_hit(input logic en, input logic [REG_W-1:0] bus_addr,
                                   input logic [REG_W-1:0] addr);
    return en && (bus_addr == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: EX/MEM result beats MEM/WB, which beats the
// value read from the register file during decode.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_mem_wr_en,
  input  logic [REG_W-1:0]  i_mem_wr_addr,
  input  logic [DATA_W-1:0] i_mem_wr_data,
  input  logic              i_wb_wr_en,
  input  logic [REG_W-1:0]  i_wb_wr_addr,
  input  logic [DATA_W-1:0] i_wb_wr_data,
  output logic [DATA_W-1:0] o_fwd_data
);

  always_comb begin
    o_fwd_data = i_reg_data;
    if (bus_hit(i_mem_wr_en, i_mem_wr_addr, i_addr))
      o_fwd_data = i_mem_wr_data;
    else if (bus_hit(i_wb_wr_en, i_wb_wr_addr, i_addr))
      o_fwd_data = i_wb_wr_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB and a
// one-cycle load-use stall; presents final op/in1/in2 to the execute ALU.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_src_sel,
  input  logic [REG_W-1:0]  id_rs_addr,
  input  logic [REG_W-1:0]  id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_shamt,
  input  logic              id_wr_en,
  input  logic [REG_W-1:0]  id_wr_addr,
  input  logic              id_mem_read,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              mem_wr_en,
  input  logic [REG_W-1:0]  mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              wb_wr_en,
  input  logic [REG_W-1:0]  wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_wr_en,
  output logic [REG_W-1:0]  ex_wr_addr,
  output logic              ex_mem_read
);

  id_ex_t            r_q;
  id_ex_t            w_d;
  logic              w_load_use;
  logic [DATA_W-1:0] w_rs_f;
  logic [DATA_W-1:0] w_rt_f;

  // Both sources are compared whatever src_sel says: cheaper, and only
  // costs an occasional needless bubble.
  assign w_load_use = r_q.valid && r_q.mem_read && (r_q.wr_addr != '0) && id_valid &&
                      ((r_q.wr_addr == id_rs_addr) || (r_q.wr_addr == id_rt_addr));

  assign id_stall = ex_stall || (w_load_use && !flush);

  always_comb begin
    w_d.valid    = id_valid;
    w_d.alu_op   = id_alu_op;
    w_d.src_sel  = src_sel_t'(id_src_sel);
    w_d.rs_addr  = id_rs_addr;
    w_d.rt_addr  = id_rt_addr;
    w_d.rs_data  = id_rs_data;
    w_d.rt_data  = id_rt_data;
    w_d.imm      = id_imm;
    w_d.shamt    = id_shamt;
    w_d.wr_en    = id_wr_en;
    w_d.wr_addr  = id_wr_addr;
    w_d.mem_read = id_mem_read;
  end

  // Bubbles only clear the side-effecting bits; the rest of the slot is dead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (flush || (!ex_stall && w_load_use)) begin
      r_q.valid    <= 1'b0;
      r_q.wr_en    <= 1'b0;
      r_q.mem_read <= 1'b0;
    end else if (!ex_stall) begin
      r_q <= w_d;
    end
  end

  fwd_mux u_fwd_rs (
    .i_addr        (r_q.rs_addr),
    .i_reg_data    (r_q.rs_data),
    .i_mem_wr_en   (mem_wr_en),
    .i_mem_wr_addr (mem_wr_addr),
    .i_mem_wr_data (mem_wr_data),
    .i_wb_wr_en    (wb_wr_en),
    .i_wb_wr_addr  (wb_wr_addr),
    .i_wb_wr_data  (wb_wr_data),
    .o_fwd_data    (w_rs_f)
  );

  fwd_mux u_fwd_rt (
    .i_addr        (r_q.rt_addr),
    .i_reg_data    (r_q.rt_data),
    .i_mem_wr_en   (mem_wr_en),
    .i_mem_wr_addr (mem_wr_addr),
    .i_mem_wr_data (mem_wr_data),
    .i_wb_wr_en    (wb_wr_en),
    .i_wb_wr_addr  (wb_wr_addr),
    .i_wb_wr_data  (wb_wr_data),
    .o_fwd_data    (w_rt_f)
  );

  always_comb begin
    ex_in1 = w_rs_f;
    ex_in2 = w_rt_f;
    case (r_q.src_sel)
      SRC_RR:    begin ex_in1 = w_rs_f; ex_in2 = w_rt_f; end
      SRC_RI:    begin ex_in1 = w_rs_f; ex_in2 = r_q.imm; end
      SRC_SHAMT: begin ex_in1 = w_rt_f; ex_in2 = {{(DATA_W-REG_W){1'b0}}, r_q.shamt}; end
      SRC_SHV:   begin ex_in1 = w_rt_f; ex_in2 = w_rs_f; end
      default:   begin ex_in1 = w_rs_f; ex_in2 = w_rt_f; end
    endcase
  end

  assign ex_store_data = w_rt_f;
  assign ex_valid      = r_q.valid;
  assign ex_alu_op     = r_q.alu_op;
  assign ex_wr_en      = r_q.wr_en;
  assign ex_wr_addr    = r_q.wr_addr;
  assign ex_mem_read   = r_q.mem_read;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits between decode and the `alu` in the execute stage. It latches the decoded instruction each cycle and resolves RAW hazards combinationally from the EX/MEM and MEM/WB result buses. It presents final `op`/`in1`/`in2` to the ALU and stalls decode for one cycle on a load-use dependency.

## Interface
Parameters: none. The datapath is fixed at 32 bits and register addresses at 5 bits.

- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `id_valid` in 1 — decode presents an instruction.
- `id_alu_op` in 4 — ALU opcode, `ALU_*` encodings from `definitions.vh`.
- `id_src_sel` in 2 — operand source select (see Operation).
- `id_rs_addr`, `id_rt_addr` in 5 — source register numbers.
- `id_rs_data`, `id_rt_data` in 32 — register-file read data.
- `id_imm` in 32 — already sign/zero-extended immediate.
- `id_shamt` in 5 — shift amount field.
- `id_wr_en` in 1, `id_wr_addr` in 5 — destination register write.
- `id_mem_read` in 1 — the instruction is a load.
- `ex_stall` in 1 — downstream freeze; the whole pipeline holds.
- `flush` in 1 — kill the instruction entering EX (branch redirect).
- `mem_wr_en` in 1, `mem_wr_addr` in 5, `mem_wr_data` in 32 — EX/MEM result bus.
- `wb_wr_en` in 1, `wb_wr_addr` in 5, `wb_wr_data` in 32 — MEM/WB result bus.
- `id_stall` out 1 — hold PC and IF/ID.
- `ex_valid` out 1 — the EX slot holds a live instruction.
- `ex_alu_op` out 4 — to ALU `op`.
- `ex_in1`, `ex_in2` out 32 — to ALU `in1`, `in2`.
- `ex_store_data` out 32 — forwarded rt value, used for stores.
- `ex_wr_en`, `ex_mem_read` out 1; `ex_wr_addr` out 5 — control carried forward.

## Operation
- **Registered fields.** `valid`, `alu_op`, `src_sel`, rs/rt addr+data, `imm`, `shamt`, `wr_en`, `wr_addr`, `mem_read`.
- **Register update priority** (evaluated each rising edge):
  - `rst`: all registered fields become 0.
  - else `flush`: `valid`, `wr_en` and `mem_read` become 0; other fields don't-care. `flush` wins over `ex_stall`.
  - else `ex_stall`: hold all fields.
  - else `load_use`: insert a bubble, which has the same effect as `flush`.
  - else: load all fields from the `id_*` inputs.
- **`load_use` detection.**
  - Condition: `ex_valid & ex_mem_read & ex_wr_addr != 0 & id_valid & (ex_wr_addr == id_rs_addr | ex_wr_addr == id_rt_addr)`.
  - Both sources are compared regardless of `src_sel`, so stalls are conservative.
- **`id_stall` output.** `id_stall = ex_stall | (load_use & ~flush)`.
- **Forwarding.** Applied per source operand (rs, rt), combinationally from the registered address and data:
  - If `mem_wr_en` and `mem_wr_addr == addr` and `addr != 0`: use `mem_wr_data`.
  - Else if `wb_wr_en` and `wb_wr_addr == addr` and `addr != 0`: use `wb_wr_data`.
  - Else use the registered data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- **Operand select.** Applied after forwarding; `rs_f`/`rt_f` are the forwarded values.
  - 0 `SRC_RR`: in1=`rs_f`, in2=`rt_f`.
  - 1 `SRC_RI`: in1=`rs_f`, in2=`imm`.
  - 2 `SRC_SHAMT`: in1=`rt_f`, in2=`{27'b0, shamt}`.
  - 3 `SRC_SHV`: in1=`rt_f`, in2=`rs_f`. The ALU uses only `in2[4:0]`.
- `ex_store_data` = `rt_f` always.
- `ex_alu_op`, `ex_wr_*`, `ex_mem_read` are driven straight from the registers.

## Timing
- ID→EX latency is 1 cycle. Forwarding and operand select add 0 cycles (combinational within the EX cycle).
- **After reset:** `ex_valid`=0, `ex_alu_op`=0, `ex_wr_en`=0, `ex_wr_addr`=0, `ex_mem_read`=0. `ex_in1`/`ex_in2`/`ex_store_data`=0 unless a result bus forwards; register 0 is never forwarded.
- **Load-use:** `id_stall` is high for exactly one cycle. The next EX slot is a bubble, and the dependent instruction enters the cycle after. It then receives load data via the MEM/WB path (`wb_wr_data`).
- **During `ex_stall`:** the registered state is frozen. Outputs remain a function of the frozen state and of the result buses, which are themselves frozen.
- **`rst` mid-stall or mid-load-use:** cleared to reset values on that edge. `id_stall` follows `ex_stall` only.

## Structure
- Package `pipe_pkg`:
  - `src_sel_t` enum with `SRC_RR`, `SRC_RI`, `SRC_SHAMT`, `SRC_SHV`.
  - `REG_W`=5 and `DATA_W`=32 constants.
  - `id_ex_t` packed struct holding the registered fields.
- ALU opcodes remain in `definitions.vh`.
- Sub-module `fwd_mux`:
  - Inputs: addr, reg data, and the two result buses.
  - Output: forwarded data.
  - Instantiated twice (rs, rt).

## Test plan
- **EX/MEM forward:** EX holds `add` rs=5, reg data 0; `mem_wr_en`=1, addr 5, data 0x10 → `ex_in1`=0x10.
- **Forward priority:** mem (addr 5, 0xAA) and wb (addr 5, 0xBB) both match rs=5 → `ex_in1`=0xAA. With `mem_wr_en`=0 → 0xBB.
- **Register 0:** rs=0, `mem_wr_addr`=0, data 0xFFFF_FFFF, `mem_wr_en`=1 → `ex_in1` = registered rs data (0).
- **Load-use:** EX `lw` to r3, ID `add` with rt=3.
  - `id_stall`=1 for one cycle.
  - Next cycle `ex_valid`=0.
  - The following cycle `ex_valid`=1 with the add; `wb_wr_data` 0x1234 for r3 → `ex_in2`=0x1234.
- **Flush vs stall:** `flush`=1 together with `ex_stall`=1 → next cycle `ex_valid`=0, `ex_wr_en`=0. `ex_stall` alone holds the prior `ex_alu_op`/`ex_in*` unchanged for 3 cycles.
- **Operand select:**
  - `SRC_SHAMT`, rt=0x1, shamt=4 → `ex_in1`=1, `ex_in2`=4.
  - `SRC_RI`, imm 0xFFFF_8000 → `ex_in2`=0xFFFF_8000.
  - `SRC_SHV`, rs=0x23 → `ex_in2`=0x23.
